// File: rtl/dce_cerr_pkg.sv
// Shared widths, types and helpers for the DCE correctable-error logger.
// The DCE_CERR_TOTAL_CNT_EN build option is handled in dce_cerr_logger.
package dce_cerr_pkg;

    localparam int W_CNT_DEF  = 8;
    localparam int W_INFO_DEF = 20;

    typedef logic [W_CNT_DEF-1:0]  cerr_cnt_t;
    typedef logic [W_INFO_DEF-1:0] cerr_info_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/dce_cerr_pri_sel.sv
// Counts the active error strobes and selects the lowest-index active source
// together with its info field. Purely combinational.
module dce_cerr_pri_sel
    import dce_cerr_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int W_INFO  = W_INFO_DEF,
    localparam int PW     = $clog2(NUM_SRC + 1),
    localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]        ev,
    input  logic [NUM_SRC*W_INFO-1:0] info_vec,
    output logic [PW-1:0]             pop,
    output logic [SW-1:0]             sel_idx,
    output logic [W_INFO-1:0]         sel_info
);

    logic [31:0] ev_ext;

    assign ev_ext = 32'(ev);
    assign pop    = PW'(popcount(ev_ext));

    // Scan from the top down so the lowest-index active source is written last.
    always_comb begin
        sel_idx  = '0;
        sel_info = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (ev[i]) begin
                sel_idx  = SW'(i);
                sel_info = info_vec[i*W_INFO +: W_INFO];
            end
        end
    end

endmodule

// File: rtl/dce_cerr_logger.sv
// DCE correctable-error status/interrupt logger (ErrVld/ErrOvf/ErrCount/ErrSrc/ErrInfo, irq_c).
// Define DCE_CERR_TOTAL_CNT_EN to add the saturating 32-bit err_total_cnt debug counter.
module dce_cerr_logger
    import dce_cerr_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int W_CNT   = W_CNT_DEF,
    parameter int W_INFO  = W_INFO_DEF,
    localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC-1:0]        err_det_vec,
    input  logic [NUM_SRC*W_INFO-1:0] err_info_vec,
    input  logic                      ErrDetEn,
    input  logic                      ErrIntEn,
    input  logic [W_CNT-1:0]          ErrThreshold,
    input  logic                      ErrVld_w1c_en,
    input  logic                      ErrOvf_w1c_en,
    output logic                      ErrVld,
    output logic                      ErrOvf,
    output logic [W_CNT-1:0]          ErrCount,
    output logic [SW-1:0]             ErrSrc,
    output logic [W_INFO-1:0]         ErrInfo,
    output logic                      irq_c
`ifdef DCE_CERR_TOTAL_CNT_EN
    ,
    output logic [31:0]               err_total_cnt
`endif
);

    localparam int PW   = $clog2(NUM_SRC + 1);
    localparam int SUMW = W_CNT + 3;

    logic [NUM_SRC-1:0] ev;
    logic [PW-1:0]      pop;
    logic [SW-1:0]      sel_idx;
    logic [W_INFO-1:0]  sel_info;
    logic [SUMW-1:0]    sum;
    logic               over;
    logic               ovf_set;

    logic              err_vld_q, err_vld_d;
    logic              err_ovf_q, err_ovf_d;
    logic [W_CNT-1:0]  err_cnt_q, err_cnt_d;
    logic [SW-1:0]     err_src_q, err_src_d;
    logic [W_INFO-1:0] err_info_q, err_info_d;
    logic              irq_q, irq_d;

    assign ev   = err_det_vec & {NUM_SRC{ErrDetEn}};
    assign sum  = {3'b000, err_cnt_q} + SUMW'(pop);
    assign over = sum > {3'b000, ErrThreshold};

    dce_cerr_pri_sel #(
        .NUM_SRC (NUM_SRC),
        .W_INFO  (W_INFO)
    ) u_pri_sel (
        .ev       (ev),
        .info_vec (err_info_vec),
        .pop      (pop),
        .sel_idx  (sel_idx),
        .sel_info (sel_info)
    );

    // A W1C of ErrVld clears first; errors in the same cycle are then either counted or overflow.
    always_comb begin
        err_vld_d  = err_vld_q;
        err_cnt_d  = err_cnt_q;
        err_src_d  = err_src_q;
        err_info_d = err_info_q;
        ovf_set    = 1'b0;
        if (ErrVld_w1c_en) begin
            err_vld_d = 1'b0;
            err_cnt_d = '0;
            if (pop != '0) begin
                if (err_vld_q || over) begin
                    ovf_set = 1'b1;
                end else begin
                    err_cnt_d = W_CNT'(pop);
                end
            end
        end else if (pop != '0) begin
            if (err_vld_q) begin
                ovf_set = 1'b1;
            end else if (over) begin
                err_vld_d  = 1'b1;
                err_cnt_d  = ErrThreshold;
                err_src_d  = sel_idx;
                err_info_d = sel_info;
            end else begin
                err_cnt_d = sum[W_CNT-1:0];
            end
        end
        err_ovf_d = ovf_set | (err_ovf_q & ~ErrOvf_w1c_en);
        irq_d     = err_vld_d & ErrIntEn;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_vld_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_cnt_q  <= '0;
            err_src_q  <= '0;
            err_info_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            err_vld_q  <= err_vld_d;
            err_ovf_q  <= err_ovf_d;
            err_cnt_q  <= err_cnt_d;
            err_src_q  <= err_src_d;
            err_info_q <= err_info_d;
            irq_q      <= irq_d;
        end
    end

    assign ErrVld   = err_vld_q;
    assign ErrOvf   = err_ovf_q;
    assign ErrCount = err_cnt_q;
    assign ErrSrc   = err_src_q;
    assign ErrInfo  = err_info_q;
    assign irq_c    = irq_q;

`ifdef DCE_CERR_TOTAL_CNT_EN
    logic [31:0] total_q, total_d;
    logic [32:0] total_sum;

    // Statistics counter ignores ErrVld and both W1Cs; it only saturates.
    assign total_sum = {1'b0, total_q} + 33'(pop);

    always_comb begin
        total_d = total_q;
        if (ErrDetEn) begin
            total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign err_total_cnt = total_q;
`endif

endmodule
